// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, one-outstanding SRAM-like fetch, decode hand-off.
// Optional FS_ADEL_EN: a misaligned fetch_pc becomes an AdEL fault entry instead of a request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_exc
);

  // state | meaning
  // REQ   | request for fetch_pc offered on the instruction port
  // WAIT  | request accepted, waiting for data_ok (dropped if cancel is set)
  // HOLD  | instruction or fault entry buffered until decode accepts it
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nx;
  logic [31:0] buf_inst;
  logic [31:0] buf_inst_nx;
  logic [31:0] br_pc;
  logic [31:0] br_pc_nx;
  logic        br_pend;
  logic        br_pend_nx;
  logic        cancel;
  logic        cancel_nx;
  logic        misaligned;
  logic        transfer;
  logic [31:0] next_pc;

`ifdef FS_ADEL_EN
  assign misaligned     = (fetch_pc[1:0] != 2'b00);
  assign inst_sram_addr = fetch_pc;
`else
  assign misaligned     = 1'b0;
  assign inst_sram_addr = {fetch_pc[31:2], 2'b00};
`endif

  assign fs_pc    = fetch_pc;
  assign transfer = fs_valid && ds_allowin;

  // A branch resolved in the same cycle its delay slot leaves is redirected directly.
  assign next_pc = br_taken ? br_target : (br_pend ? br_pc : fetch_pc + 32'd4);

  always_comb begin
    inst_sram_req = 1'b0;
    fs_valid      = 1'b0;
    fs_inst       = 32'h0;
    case (state)
      REQ: begin
        inst_sram_req = !reset && !exc_flush && !misaligned;
      end
      WAIT: begin
        if (inst_sram_data_ok && !cancel && !exc_flush) begin
          fs_valid = 1'b1;
          fs_inst  = inst_sram_rdata;
        end
      end
      HOLD: begin
        if (!exc_flush) begin
          fs_valid = 1'b1;
          fs_inst  = buf_inst;
        end
      end
      default: begin
        inst_sram_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    buf_inst_nx = buf_inst;
    br_pend_nx  = br_pend;
    br_pc_nx    = br_pc;
    cancel_nx   = cancel;

    if (exc_flush) begin
      fetch_pc_nx = exc_pc;
      br_pend_nx  = 1'b0;
      case (state)
        REQ: begin
          state_nx = REQ;
        end
        WAIT: begin
          // The accepted request still owes a response; it must not reach decode.
          if (inst_sram_data_ok) begin
            state_nx  = REQ;
            cancel_nx = 1'b0;
          end else begin
            cancel_nx = 1'b1;
          end
        end
        HOLD: begin
          state_nx = REQ;
        end
        default: begin
          state_nx = REQ;
        end
      endcase
    end else begin
      if (br_taken) begin
        br_pend_nx = 1'b1;
        br_pc_nx   = br_target;
      end

      case (state)
        REQ: begin
          if (misaligned) begin
            state_nx    = HOLD;
            buf_inst_nx = 32'h0;
          end else if (inst_sram_addr_ok) begin
            state_nx = WAIT;
          end
        end
        WAIT: begin
          if (inst_sram_data_ok) begin
            if (cancel) begin
              cancel_nx = 1'b0;
              state_nx  = REQ;
            end else if (!ds_allowin) begin
              buf_inst_nx = inst_sram_rdata;
              state_nx    = HOLD;
            end
          end
        end
        HOLD: begin
          state_nx = HOLD;
        end
        default: begin
          state_nx = REQ;
        end
      endcase

      if (transfer) begin
        fetch_pc_nx = next_pc;
        br_pend_nx  = 1'b0;
        state_nx    = REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      buf_inst <= 32'h0;
      br_pend  <= 1'b0;
      br_pc    <= 32'h0;
      cancel   <= 1'b0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      buf_inst <= buf_inst_nx;
      br_pend  <= br_pend_nx;
      br_pc    <= br_pc_nx;
      cancel   <= cancel_nx;
    end
  end

`ifdef FS_ADEL_EN
  logic buf_exc;
  logic buf_exc_nx;

  always_comb begin
    buf_exc_nx = buf_exc;
    if (exc_flush || transfer) begin
      buf_exc_nx = 1'b0;
    end else if (state == REQ && misaligned) begin
      buf_exc_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_exc <= 1'b0;
    end else begin
      buf_exc <= buf_exc_nx;
    end
  end

  assign fs_exc = fs_valid && buf_exc;
`else
  assign fs_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reactive SRAM slave, transaction-level fetch model, directed plan then random traffic.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef FS_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        exc_flush = 1'b0;
  logic [31:0] exc_pc = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        ds_allowin = 1'b0;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_exc;

  int compared = 0;
  int mismatched = 0;

  // fetch model: next PC owed to decode, pending redirect, outstanding/held entry
  logic [31:0] m_pc, m_tgt, m_held_inst;
  bit          m_pend, m_wait, m_stale, m_held, m_held_exc;
  // SRAM slave
  bit          s_pend;
  logic [31:0] s_addr;
  int          s_dcnt, s_rw, aok_lat, dok_lat, drop_cnt;
  logic [31:0] req_log[$];
  logic [31:0] xfer_log[$];
  bit          xfer_exc_log[$];
  logic [31:0] mem_ovr[logic [31:0]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
    .exc_flush(exc_flush), .exc_pc(exc_pc), .inst_sram_req(req), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .ds_allowin(ds_allowin), .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_exc(fs_exc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_ovr.exists(w)) return mem_ovr[w];
    return (w * 32'h9E37_79B1) ^ 32'h2402_0005;
  endfunction

  function automatic bit fault_pc(input logic [31:0] pc);
    return ADEL && (pc[1:0] != 2'b00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    xfer_log.delete();
    xfer_exc_log.delete();
  endtask

  task automatic tick(input bit fl, input logic [31:0] epc, input bit br,
                      input logic [31:0] tgt, input bit allow);
    bit          idle, exp_req, exp_valid, exp_exc, resp, xfer, acc;
    logic [31:0] exp_inst;
    @(negedge clk);
    exc_flush  = fl;
    exc_pc     = epc;
    br_taken   = br;
    br_target  = tgt;
    ds_allowin = allow;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    #1;
    idle    = !m_wait && !m_held;
    exp_req = idle && !fl && !fault_pc(m_pc);
    chk("req", 32'(req), 32'(exp_req));
    if (exp_req) chk("addr", addr, ADEL ? m_pc : {m_pc[31:2], 2'b00});
    addr_ok = req && !s_pend && (s_rw >= aok_lat);
    data_ok = s_pend && (s_dcnt >= dok_lat);
    rdata   = data_ok ? mem_word(s_addr) : $urandom;
    #1;
    resp      = data_ok && m_wait && !m_stale;
    exp_valid = !fl && (m_held || resp);
    exp_inst  = m_held ? m_held_inst : mem_word(m_pc);
    exp_exc   = m_held && m_held_exc;
    chk("fs_valid", 32'(fs_valid), 32'(exp_valid));
    chk("fs_pc", fs_pc, m_pc);
    if (exp_valid) begin
      chk("fs_inst", fs_inst, exp_inst);
      chk("fs_exc", 32'(fs_exc), 32'(exp_exc));
    end else begin
      chk("fs_exc_idle", 32'(fs_exc), 32'h0);
    end

    xfer = exp_valid && allow;
    acc  = req && addr_ok;
    if (acc) begin
      req_log.push_back(addr);
      s_pend = 1'b1;
      s_addr = addr;
      s_dcnt = 0;
    end else if (data_ok) begin
      s_pend = 1'b0;
    end else if (s_pend) begin
      s_dcnt++;
    end
    s_rw = (req && !addr_ok) ? s_rw + 1 : 0;
    if (data_ok && !exp_valid) drop_cnt++;
    if (xfer) begin
      xfer_log.push_back(m_pc);
      xfer_exc_log.push_back(exp_exc);
    end

    if (fl) begin
      m_pc   = epc;
      m_pend = 1'b0;
      m_held = 1'b0;
      if (m_wait) begin
        if (data_ok) m_wait = 1'b0;
        else m_stale = 1'b1;
      end
    end else begin
      if (data_ok && m_wait) begin
        m_wait = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (!allow) begin
          m_held      = 1'b1;
          m_held_inst = mem_word(m_pc);
          m_held_exc  = 1'b0;
        end
      end
      if (acc) begin
        m_wait  = 1'b1;
        m_stale = 1'b0;
      end
      if (idle && fault_pc(m_pc)) begin
        m_held      = 1'b1;
        m_held_inst = 32'h0;
        m_held_exc  = 1'b1;
      end
      if (xfer) begin
        m_held = 1'b0;
        m_pc   = br ? tgt : (m_pend ? m_tgt : m_pc + 32'd4);
        m_pend = 1'b0;
      end else if (br) begin
        m_pend = 1'b1;
        m_tgt  = tgt;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    exc_flush = 1'b0; br_taken = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; ds_allowin = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_fs_pc", fs_pc, RST_PC);
    chk("rst_fs_valid", 32'(fs_valid), 32'h0);
    chk("rst_fs_inst", fs_inst, 32'h0);
    chk("rst_fs_exc", 32'(fs_exc), 32'h0);
    m_pc = RST_PC; m_pend = 1'b0; m_wait = 1'b0; m_stale = 1'b0; m_held = 1'b0; s_rw = 0;
    repeat (2) begin
      @(posedge clk);
      if (s_pend) s_dcnt++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("req_after_reset", 32'(req), 32'h1);
  endtask

  task automatic run_xfers(input int n, input int budget, input string tag);
    int k = 0;
    while (xfer_log.size() < n && k < budget) begin
      tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      k++;
    end
    chk(tag, xfer_log.size(), n);
  endtask

  task automatic wait_reqs(input int n, input int budget, input string tag);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      k++;
    end
    chk(tag, req_log.size(), n);
  endtask

  initial begin
    int hits;
    int drop0;
    bit fl, br, allow;
    logic [31:0] epc, tgt;
    s_pend = 1'b0; s_dcnt = 0; drop_cnt = 0;

    // sequential fetch, addr_ok/data_ok one cycle late
    aok_lat = 1; dok_lat = 1;
    do_reset();
    clear_logs();
    run_xfers(3, 40, "t1_xfers");
    chk("t1_req0", req_log[0], 32'hBFC0_0000);
    chk("t1_req1", req_log[1], 32'hBFC0_0004);
    chk("t1_req2", req_log[2], 32'hBFC0_0008);
    chk("t1_xfer2", xfer_log[2], 32'hBFC0_0008);

    // decode stalls for three cycles on a returned word
    mem_ovr[RST_PC] = 32'h2402_0005;
    aok_lat = 0; dok_lat = 0;
    do_reset();
    clear_logs();
    repeat (4) tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t2_held_valid", 32'(fs_valid), 32'h1);
    chk("t2_held_inst", fs_inst, 32'h2402_0005);
    chk("t2_one_req", req_log.size(), 1);
    run_xfers(1, 5, "t2_xfer");
    wait_reqs(2, 5, "t2_reqs");
    chk("t2_next_req", req_log[1], 32'hBFC0_0004);

    // branch while the delay slot is in WAIT
    aok_lat = 0; dok_lat = 2;
    clear_logs();
    tick(1'b1, 32'h8000_0FF4, 1'b0, 32'h0, 1'b1);
    wait_reqs(1, 10, "t3_ds_req");
    tick(1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1);
    run_xfers(2, 20, "t3_xfers");
    chk("t3_ds_pc", xfer_log[0], 32'h8000_0FF4);
    chk("t3_tgt_pc", xfer_log[1], 32'h8000_1000);
    chk("t3_tgt_req", req_log[1], 32'h8000_1000);

    // flush in WAIT, response two cycles later is dropped
    clear_logs();
    wait_reqs(1, 10, "t4_req");
    drop0 = drop_cnt;
    tick(1'b1, 32'hBFC0_0380, 1'b0, 32'h0, 1'b1);
    clear_logs();
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t4_dropped", drop_cnt - drop0, 1);
    chk("t4_no_xfer", xfer_log.size(), 0);
    run_xfers(1, 10, "t4_xfer");
    chk("t4_req", req_log[0], 32'hBFC0_0380);
    chk("t4_xfer_pc", xfer_log[0], 32'hBFC0_0380);

    // flush and branch together
    clear_logs();
    tick(1'b1, 32'h9000_0000, 1'b1, 32'hA000_0000, 1'b1);
    run_xfers(3, 30, "t5_xfers");
    hits = 0;
    foreach (req_log[i]) if (req_log[i] == 32'hA000_0000) hits++;
    chk("t5_no_target", hits, 0);
    chk("t5_req0", req_log[0], 32'h9000_0000);
    chk("t5_xfer1", xfer_log[1], 32'h9000_0004);

`ifdef FS_ADEL_EN
    // misaligned branch target raises AdEL without a request
    clear_logs();
    tick(1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1);
    wait_reqs(1, 10, "t6_ds_req");
    tick(1'b0, 32'h0, 1'b1, 32'h8000_0002, 1'b1);
    run_xfers(2, 20, "t6_xfers");
    chk("t6_fault_pc", xfer_log[1], 32'h8000_0002);
    chk("t6_fault_exc", 32'(xfer_exc_log[1]), 32'h1);
    chk("t6_no_req", req_log.size(), 1);
`endif

    // reset while a request is outstanding; late response is ignored
    aok_lat = 0; dok_lat = 3;
    clear_logs();
    tick(1'b1, 32'h8000_2000, 1'b0, 32'h0, 1'b1);
    wait_reqs(1, 10, "t7_req");
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    do_reset();
    clear_logs();
    drop0 = drop_cnt;
    run_xfers(1, 30, "t7_xfer");
    chk("t7_orphan_dropped", drop_cnt - drop0, 1);
    chk("t7_req", req_log[0], RST_PC);
    chk("t7_xfer_pc", xfer_log[0], RST_PC);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      aok_lat = $urandom_range(0, 2);
      dok_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 599) == 0) do_reset();
      fl = ($urandom_range(0, 19) == 0);
      epc = $urandom;
      if ($urandom_range(0, 7) != 0) epc[1:0] = 2'b00;
      br = ($urandom_range(0, 5) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      allow = ($urandom_range(0, 9) < 7);
      tick(fl, epc, br, tgt, allow);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (F) stage of the f-d-e-m-w pipeline.
- Generates the PC and issues one-outstanding requests on the SRAM-like instruction port.
- Holds the returned instruction until the decode pipeline register accepts it. Its fs_valid/fs_pc/fs_inst drive decode's pre_valid/pre_pc/pre_instruction; ds_allowin is decode's cur_allowin.
- Applies branch redirects (delay slot preserved) and exception flushes.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- br_taken  input  1  decode resolved a taken branch/jump this cycle.
- br_target  input  32  redirect target, valid with br_taken.
- exc_flush  input  1  exception/eret flush from writeback.
- exc_pc  input  32  refetch address, valid with exc_flush.
- inst_sram_req  output  1  request valid.
- inst_sram_addr  output  32  request address.
- inst_sram_addr_ok  input  1  request accepted this cycle.
- inst_sram_data_ok  input  1  read data returned this cycle.
- inst_sram_rdata  input  32  read data.
- ds_allowin  input  1  decode can accept this cycle.
- fs_valid  output  1  instruction presented to decode.
- fs_pc  output  32  PC of presented instruction.
- fs_inst  output  32  presented instruction word.
- fs_exc  output  1  presented instruction has an AdEL fetch fault.

Behaviour:
- State: fetch_pc[31:0], buf_inst[31:0], br_pend, br_pc[31:0], cancel, FSM {REQ, WAIT, HOLD}.
- Reset (async):
  - fetch_pc=RESET_PC; state=REQ; br_pend=0; cancel=0.
  - All outputs 0, except inst_sram_addr=RESET_PC and fs_pc=RESET_PC.
  - req rises in the first cycle after reset deasserts.
- REQ:
  - req=1, addr=fetch_pc.
  - On addr_ok, go to WAIT.
  - Address may be rewritten by a flush while not yet accepted.
- WAIT:
  - req=0.
  - On data_ok with cancel=0, present rdata combinationally: fs_valid=1, fs_inst=inst_sram_rdata.
  - If ds_allowin the same cycle, the instruction transfers and the FSM goes to REQ with the next PC.
  - Otherwise capture into buf_inst and go to HOLD.
- HOLD:
  - fs_valid=1, fs_inst=buf_inst.
  - On ds_allowin, transfer and go to REQ with the next PC.
- Transfer occurs when fs_valid && ds_allowin.
- Next PC after a transfer: br_pend ? br_pc : fetch_pc+4 (32-bit wrap).
  - br_pend is cleared when br_pc is consumed.
  - fs_pc=fetch_pc at all times.
- Branch redirect:
  - br_taken sets br_pend=1 and br_pc=br_target.
  - It never cancels the in-flight or held instruction, which is the delay slot.
  - br_taken while br_pend=1 overwrites br_pc.
- Exception flush (priority over everything):
  - exc_flush forces fs_valid=0 that cycle, so no transfer occurs.
  - Sets fetch_pc=exc_pc and clears br_pend.
  - In REQ: stay in REQ with the new address.
  - In HOLD: discard the buffer and go to REQ.
  - In WAIT without data_ok that cycle: set cancel=1 and stay in WAIT.
  - In WAIT with data_ok that cycle: discard the data and go to REQ.
- cancel=1 in WAIT: the next data_ok is dropped (fs_valid stays 0), cancel clears, and the FSM goes to REQ.
- Only one request is outstanding, so a stale response cannot reach decode.
- Simultaneous exc_flush and br_taken: flush wins; br_taken is ignored.
- Reset mid-request: state is discarded. A response that arrives after reset is ignored, because the FSM is in REQ and data_ok is only observed in WAIT.

Optional Feature:
- Macro FS_ADEL_EN.
- Defined:
  - In REQ with fetch_pc[1:0]!=0, assert no request; go directly to HOLD with buf_inst=0 and fs_exc=1.
  - fs_exc clears when that entry transfers or is flushed.
- Undefined:
  - inst_sram_addr={fetch_pc[31:2],2'b00}; fs_exc is tied to 0.

Test Plan:
- Reset release, addr_ok/data_ok each 1 cycle late, ds_allowin=1 -> requests to BFC00000, BFC00004, BFC00008; each fs_valid pulse carries the matching rdata.
- data_ok=1 with rdata=0x24020005 while ds_allowin=0 for 3 cycles -> fs_valid held, fs_inst=0x24020005 from buf_inst; next request is BFC00004 only after the transfer.
- br_taken, br_target=0x80001000 while the instruction at 0x80000FF4 is in WAIT -> that delay slot transfers, then the next request is 0x80001000.
- exc_flush, exc_pc=0xBFC00380 in WAIT, data_ok 2 cycles later -> that data is dropped (fs_valid=0), then a request to 0xBFC00380.
- exc_flush and br_taken asserted together -> next request is exc_pc; br_target is never fetched.
- FS_ADEL_EN defined, br_target=0x80000002 -> no SRAM request; fs_valid=1, fs_exc=1, fs_inst=0, fs_pc=0x80000002.
